// File: rtl/spi_cfg_commit_pkg.sv
// Shared state encoding, field widths and counter sizing for the SPI config commit sequencer.
package spi_cfg_commit_pkg;

  localparam int unsigned TrigLockoutW = 32;
  localparam int unsigned IntegThreshW = 15;
  localparam int unsigned IntegWindowW = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPending = 3'd1,
    StApply   = 3'd2,
    StSettle  = 3'd3,
    StFault   = 3'd4
  } cfg_state_e;

  // Bits needed to count 0..limit inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/cfg_hold_counter.sv
// Saturating up-counter with synchronous clear; term flags that the next increment reaches Limit.
module cfg_hold_counter
  import spi_cfg_commit_pkg::*;
#(
  parameter int unsigned Limit = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam int unsigned Width = cnt_width(Limit);
  localparam logic [Width-1:0] LimitVal = Width'(Limit);
  localparam logic [Width-1:0] LastVal  = (Limit == 0) ? '0 : Width'(Limit - 1);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != LimitVal)) begin
      count_q <= count_q + Width'(1);
    end
  end

  // A zero limit means the counter never terminates (feature disabled).
  assign term = (Limit != 0) && (count_q == LastVal);

endmodule

// File: rtl/spi_cfg_commit_ctrl.sv
// Commits synchronized SPI config to the datapath once stable and idle, then holds off.
// Optional commit counter output enabled by defining SPI_CFG_COMMIT_COUNT_EN.
module spi_cfg_commit_ctrl
  import spi_cfg_commit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cfg_valid,
  input  logic [TrigLockoutW-1:0] trig_lockout_in,
  input  logic [IntegThreshW-1:0] integ_thresh_avg_in,
  input  logic [IntegWindowW-1:0] integ_window_in,
  input  logic                    integ_en_in,
  input  logic                    spi_en_in,
  input  logic                    dp_busy,
  output logic [TrigLockoutW-1:0] trig_lockout,
  output logic [IntegThreshW-1:0] integ_thresh_avg,
  output logic [IntegWindowW-1:0] integ_window,
  output logic                    integ_en,
  output logic                    spi_en,
  output logic                    cfg_load,
  output logic                    cfg_pending,
  output logic                    cfg_timeout,
`ifdef SPI_CFG_COMMIT_COUNT_EN
  output logic [15:0]             commit_count,
`endif
  output logic [2:0]              state
);

  cfg_state_e state_q, state_d;

  logic [TrigLockoutW-1:0] trig_q, trig_d;
  logic [IntegThreshW-1:0] thresh_q, thresh_d;
  logic [IntegWindowW-1:0] window_q, window_d;
  logic                    integ_en_q, integ_en_d;
  logic                    spi_en_q, spi_en_d;

  logic change, disable_req;
  logic tmo_term, settle_term;

  assign change = cfg_valid && spi_en_in &&
                  ({trig_lockout_in, integ_thresh_avg_in, integ_window_in, integ_en_in, spi_en_in}
                   != {trig_q, thresh_q, window_q, integ_en_q, spi_en_q});

  assign disable_req = cfg_valid && !spi_en_in && spi_en_q;

  // Timeout count restarts every time we leave IDLE; it holds its value in FAULT.
  cfg_hold_counter #(
    .Limit(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk   (clk),
    .resetn(resetn),
    .clr   (disable_req || (state_q == StIdle)),
    .inc   ((state_q == StPending) && cfg_valid && dp_busy),
    .term  (tmo_term)
  );

  cfg_hold_counter #(
    .Limit(SETTLE_CYCLES)
  ) u_settle_cnt (
    .clk   (clk),
    .resetn(resetn),
    .clr   (disable_req || (state_q == StApply)),
    .inc   (state_q == StSettle),
    .term  (settle_term)
  );

  always_comb begin
    state_d    = state_q;
    trig_d     = trig_q;
    thresh_d   = thresh_q;
    window_d   = window_q;
    integ_en_d = integ_en_q;
    spi_en_d   = spi_en_q;

    if (disable_req) begin
      spi_en_d = 1'b0;
      state_d  = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (change) state_d = StPending;
        end
        StPending: begin
          if (!cfg_valid) begin
            state_d = StIdle;
          end else if (!dp_busy) begin
            trig_d     = trig_lockout_in;
            thresh_d   = integ_thresh_avg_in;
            window_d   = integ_window_in;
            integ_en_d = integ_en_in;
            spi_en_d   = spi_en_in;
            state_d    = StApply;
          end else if (tmo_term) begin
            state_d = StFault;
          end
        end
        StApply: begin
          state_d = (SETTLE_CYCLES == 0) ? StIdle : StSettle;
        end
        StSettle: begin
          if (settle_term) state_d = StIdle;
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      trig_q     <= '0;
      thresh_q   <= '0;
      window_q   <= '0;
      integ_en_q <= 1'b0;
      spi_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      thresh_q   <= thresh_d;
      window_q   <= window_d;
      integ_en_q <= integ_en_d;
      spi_en_q   <= spi_en_d;
    end
  end

  assign trig_lockout     = trig_q;
  assign integ_thresh_avg = thresh_q;
  assign integ_window     = window_q;
  assign integ_en         = integ_en_q;
  assign spi_en           = spi_en_q;
  assign cfg_load         = (state_q == StApply);
  assign cfg_pending      = (state_q == StPending);
  // FAULT is left only through disable or reset, both of which clear the flag.
  assign cfg_timeout      = (state_q == StFault);
  assign state            = state_q;

`ifdef SPI_CFG_COMMIT_COUNT_EN
  logic [15:0] commit_count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      commit_count_q <= '0;
    end else if (cfg_load) begin
      commit_count_q <= commit_count_q + 16'd1;
    end
  end

  assign commit_count = commit_count_q;
`endif

endmodule

// File: tb/tb_spi_cfg_commit_ctrl.sv
// Directed bench for spi_cfg_commit_ctrl: two instances (default, and short timeout with no settle)
// checked every cycle against a rule-level model, plus literal expectations per scenario.
module tb_spi_cfg_commit_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_valid;
  logic [31:0] tl_in;
  logic [14:0] th_in;
  logic [31:0] win_in;
  logic        ie_in;
  logic        se_in;
  logic        dp_busy;

  logic [31:0] a_tl, b_tl;
  logic [14:0] a_th, b_th;
  logic [31:0] a_win, b_win;
  logic        a_ie, b_ie, a_se, b_se;
  logic        a_load, b_load, a_pend, b_pend, a_tmo, b_tmo;
  logic [2:0]  a_st, b_st;
`ifdef SPI_CFG_COMMIT_COUNT_EN
  logic [15:0] a_cc, b_cc;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  spi_cfg_commit_ctrl dut_a (
    .clk                (clk),
    .resetn             (resetn),
    .cfg_valid          (cfg_valid),
    .trig_lockout_in    (tl_in),
    .integ_thresh_avg_in(th_in),
    .integ_window_in    (win_in),
    .integ_en_in        (ie_in),
    .spi_en_in          (se_in),
    .dp_busy            (dp_busy),
    .trig_lockout       (a_tl),
    .integ_thresh_avg   (a_th),
    .integ_window       (a_win),
    .integ_en           (a_ie),
    .spi_en             (a_se),
    .cfg_load           (a_load),
    .cfg_pending        (a_pend),
    .cfg_timeout        (a_tmo),
`ifdef SPI_CFG_COMMIT_COUNT_EN
    .commit_count       (a_cc),
`endif
    .state              (a_st)
  );

  spi_cfg_commit_ctrl #(
    .TIMEOUT_CYCLES(16),
    .SETTLE_CYCLES (0)
  ) dut_b (
    .clk                (clk),
    .resetn             (resetn),
    .cfg_valid          (cfg_valid),
    .trig_lockout_in    (tl_in),
    .integ_thresh_avg_in(th_in),
    .integ_window_in    (win_in),
    .integ_en_in        (ie_in),
    .spi_en_in          (se_in),
    .dp_busy            (dp_busy),
    .trig_lockout       (b_tl),
    .integ_thresh_avg   (b_th),
    .integ_window       (b_win),
    .integ_en           (b_ie),
    .spi_en             (b_se),
    .cfg_load           (b_load),
    .cfg_pending        (b_pend),
    .cfg_timeout        (b_tmo),
`ifdef SPI_CFG_COMMIT_COUNT_EN
    .commit_count       (b_cc),
`endif
    .state              (b_st)
  );

  // Model: phase 0 idle, 1 waiting, 2 load cycle, 3 holdoff, 4 faulted.
  typedef struct {
    logic [31:0] tl;
    logic [14:0] th;
    logic [31:0] win;
    logic        ie;
    logic        se;
    int          phase;
    int          busy_cycles;
    int          hold_cycles;
    logic [15:0] loads;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mzero();
    mdl_t z;
    z.tl = '0; z.th = '0; z.win = '0; z.ie = 1'b0; z.se = 1'b0;
    z.phase = 0; z.busy_cycles = 0; z.hold_cycles = 0; z.loads = '0;
    return z;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int tmo, int stl);
    mdl_t n = m;
    bit differs = ({tl_in, th_in, win_in, ie_in, se_in} != {m.tl, m.th, m.win, m.ie, m.se});
    bit chg = cfg_valid && se_in && differs;
    bit dis = cfg_valid && !se_in && m.se;
    if (m.phase == 2) n.loads = m.loads + 16'd1;
    if (dis) begin
      n.se = 1'b0; n.phase = 0; n.busy_cycles = 0; n.hold_cycles = 0;
      return n;
    end
    case (m.phase)
      0: if (chg) begin n.phase = 1; n.busy_cycles = 0; end
      1: begin
        if (!cfg_valid) n.phase = 0;
        else if (!dp_busy) begin
          n.tl = tl_in; n.th = th_in; n.win = win_in; n.ie = ie_in; n.se = se_in;
          n.phase = 2;
        end else begin
          n.busy_cycles = m.busy_cycles + 1;
          if (tmo != 0 && n.busy_cycles >= tmo) n.phase = 4;
        end
      end
      2: begin n.phase = (stl == 0) ? 0 : 3; n.hold_cycles = 0; end
      3: begin
        n.hold_cycles = m.hold_cycles + 1;
        if (n.hold_cycles >= stl) n.phase = 0;
      end
      default: ;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ma <= mzero();
      mb <= mzero();
    end else begin
      ma <= mstep(ma, 1024, 4);
      mb <= mstep(mb, 16, 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp(input string tag, input mdl_t m, input logic [31:0] tl,
                     input logic [14:0] th, input logic [31:0] win, input logic ie,
                     input logic se, input logic load, input logic pend, input logic tmo,
                     input logic [2:0] st);
    chk({tag, ".state"}, 64'(st), 64'(m.phase));
    chk({tag, ".trig_lockout"}, 64'(tl), 64'(m.tl));
    chk({tag, ".integ_thresh"}, 64'(th), 64'(m.th));
    chk({tag, ".integ_window"}, 64'(win), 64'(m.win));
    chk({tag, ".integ_en"}, 64'(ie), 64'(m.ie));
    chk({tag, ".spi_en"}, 64'(se), 64'(m.se));
    chk({tag, ".cfg_load"}, 64'(load), 64'(m.phase == 2));
    chk({tag, ".cfg_pending"}, 64'(pend), 64'(m.phase == 1));
    chk({tag, ".cfg_timeout"}, 64'(tmo), 64'(m.phase == 4));
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp("a", ma, a_tl, a_th, a_win, a_ie, a_se, a_load, a_pend, a_tmo, a_st);
      cmp("b", mb, b_tl, b_th, b_win, b_ie, b_se, b_load, b_pend, b_tmo, b_st);
`ifdef SPI_CFG_COMMIT_COUNT_EN
      chk("a.commit_count", 64'(a_cc), 64'(ma.loads));
      chk("b.commit_count", 64'(b_cc), 64'(mb.loads));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int pcount;
  int b_fault_at;

  initial begin
    resetn = 1'b0; cfg_valid = 1'b0; tl_in = '0; th_in = '0; win_in = '0;
    ie_in = 1'b0; se_in = 1'b0; dp_busy = 1'b0;
    repeat (3) tick();
    check_en = 1'b1;
    chk("reset.state", 64'(a_st), 64'd0);
    chk("reset.spi_en", 64'(a_se), 64'd0);
    resetn = 1'b1;

    // 1: first enable commits at +2 and settles for four cycles
    cfg_valid = 1'b1; se_in = 1'b1; tl_in = 32'h100;
    tick();
    chk("t1.pending_at_1", 64'(a_st), 64'd1);
    tick();
    chk("t1.apply_at_2", 64'(a_st), 64'd2);
    chk("t1.load_at_2", 64'(a_load), 64'd1);
    chk("t1.trig", 64'(a_tl), 64'h100);
    chk("t1.spi_en", 64'(a_se), 64'd1);
    tick();
    chk("t1.settle", 64'(a_st), 64'd3);
    chk("t1.load_one_cycle", 64'(a_load), 64'd0);
    chk("t1.b_no_settle", 64'(b_st), 64'd0);
    repeat (3) tick();
    chk("t1.settle_last", 64'(a_st), 64'd3);
    tick();
    chk("t1.idle", 64'(a_st), 64'd0);

    // 2 and 3: busy datapath for 50 cycles; short-timeout instance faults
    dp_busy = 1'b1; win_in = 32'h2000;
    pcount = 0; b_fault_at = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (a_pend) pcount++;
      if (b_st == 3'd4 && b_fault_at == 0) b_fault_at = i;
    end
    chk("t2.pending_cycles", 64'(pcount), 64'd50);
    chk("t3.fault_cycle", 64'(b_fault_at), 64'd17);
    chk("t3.timeout_flag", 64'(b_tmo), 64'd1);
    chk("t3.window_held", 64'(b_win), 64'd0);
    dp_busy = 1'b0;
    tick();
    chk("t2.load", 64'(a_load), 64'd1);
    chk("t2.window", 64'(a_win), 64'h2000);
    chk("t3.fault_holds", 64'(b_st), 64'd4);
    tick();
    se_in = 1'b0;
    tick();
    chk("t3.dis_spi_en", 64'(b_se), 64'd0);
    chk("t3.dis_timeout", 64'(b_tmo), 64'd0);
    chk("t3.dis_state", 64'(b_st), 64'd0);
    chk("t3.dis_trig_kept", 64'(b_tl), 64'h100);
    chk("t3.a_dis_state", 64'(a_st), 64'd0);

    // 4: cfg_valid glitch in PENDING drops the change, then it is re-detected
    se_in = 1'b1; dp_busy = 1'b1;
    tick();
    chk("t4.pending", 64'(a_st), 64'd1);
    cfg_valid = 1'b0;
    tick();
    chk("t4.dropped", 64'(a_st), 64'd0);
    chk("t4.no_load", 64'(a_load), 64'd0);
    cfg_valid = 1'b1; dp_busy = 1'b0;
    tick();
    chk("t4.redetect", 64'(a_st), 64'd1);
    tick();
    chk("t4.apply", 64'(a_load), 64'd1);
    chk("t4.spi_en", 64'(a_se), 64'd1);
    repeat (5) tick();

    // 5: disable during the APPLY cycle
    tl_in = 32'h200;
    tick();
    tick();
    chk("t5.apply", 64'(a_load), 64'd1);
    chk("t5.trig", 64'(a_tl), 64'h200);
    se_in = 1'b0;
    tick();
    chk("t5.spi_en_off", 64'(a_se), 64'd0);
    chk("t5.state", 64'(a_st), 64'd0);
    chk("t5.load_dropped", 64'(a_load), 64'd0);
    tick();
    chk("t5.no_second_load", 64'(a_load), 64'd0);
`ifdef SPI_CFG_COMMIT_COUNT_EN
    chk("t6.count_a", 64'(a_cc), 64'd4);
    chk("t6.count_b", 64'(b_cc), 64'd3);
`endif

    // 6: reset in the middle of PENDING
    se_in = 1'b1; tl_in = 32'h400; dp_busy = 1'b1;
    tick();
    chk("t6.pending", 64'(a_st), 64'd1);
    resetn = 1'b0;
    #1;
    chk("t6.rst_trig", 64'(a_tl), 64'd0);
    chk("t6.rst_window", 64'(a_win), 64'd0);
    chk("t6.rst_pending", 64'(a_pend), 64'd0);
    chk("t6.rst_state", 64'(a_st), 64'd0);
`ifdef SPI_CFG_COMMIT_COUNT_EN
    chk("t6.rst_count", 64'(a_cc), 64'd0);
`endif
    tick();
    tick();
    resetn = 1'b1;

    // 7: busy drops on the same edge the timeout would fire; APPLY wins
    tl_in = 32'h300;
    tick();
    chk("t7.pending", 64'(b_st), 64'd1);
    repeat (15) tick();
    chk("t7.still_pending", 64'(b_st), 64'd1);
    dp_busy = 1'b0;
    tick();
    chk("t7.apply_wins", 64'(b_st), 64'd2);
    chk("t7.trig", 64'(b_tl), 64'h300);
    repeat (6) tick();

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_cfg_commit_ctrl.md
Name: spi_cfg_commit_ctrl

Overview:
- Sequences when synchronized SPI-domain configuration is committed to the SPI datapath (trigger lockout, integrator threshold/window, enables).
- Sits after the per-field synchronizers in the spi_clk domain.
- Detects a changed, stable config and defers commit until the datapath reports idle. Then issues a one-cycle load pulse and enforces a settle holdoff.
- Disabling SPI bypasses all sequencing; a busy datapath that never idles raises a sticky fault.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles in PENDING waiting for dp_busy low. 0 disables the timeout.
- SETTLE_CYCLES, 4: holdoff cycles after a commit before new changes are accepted. 0 skips SETTLE.

Ports:
- clk  in  1  SPI-domain clock; everything is on its rising edge.
- resetn  in  1  Asynchronous, active-low reset.
- cfg_valid  in  1  AND of all synchronizer stable flags.
- trig_lockout_in  in  32  Synchronized trigger lockout.
- integ_thresh_avg_in  in  15  Synchronized integrator threshold.
- integ_window_in  in  32  Synchronized integrator window.
- integ_en_in  in  1  Synchronized integrator enable.
- spi_en_in  in  1  Synchronized SPI enable.
- dp_busy  in  1  Datapath mid-transaction; no commit allowed.
- trig_lockout  out  32  Committed value.
- integ_thresh_avg  out  15  Committed value.
- integ_window  out  32  Committed value.
- integ_en  out  1  Committed value.
- spi_en  out  1  Committed value.
- cfg_load  out  1  One-cycle pulse, asserted in the cycle the new committed values first appear.
- cfg_pending  out  1  High while in PENDING.
- cfg_timeout  out  1  Sticky fault flag.
- state  out  3  Current FSM state, for debug.

Behaviour:
- Reset (resetn low, asynchronous): all committed outputs 0, cfg_load 0, cfg_pending 0, cfg_timeout 0, state IDLE, counters 0.
- change: cfg_valid && spi_en_in && (any *_in field != its committed output, including spi_en).
- disable: cfg_valid && !spi_en_in && spi_en.
- Disable (highest priority, any state):
  - Next cycle: spi_en=0, state=IDLE, cfg_timeout cleared, counters cleared.
  - Other committed fields are unchanged; cfg_load is not pulsed.
- IDLE:
  - change -> PENDING.
  - Timeout counter is cleared on entry to PENDING.
- PENDING:
  - cfg_pending=1.
  - !cfg_valid -> IDLE; the change is dropped and is re-detected once stable.
  - else !dp_busy -> APPLY. On this edge all five *_in are captured into the committed outputs.
  - else the counter increments. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES -> FAULT, with cfg_timeout=1.
- APPLY:
  - Lasts exactly one cycle; cfg_load=1.
  - -> SETTLE, or -> IDLE if SETTLE_CYCLES==0.
- SETTLE:
  - Counts SETTLE_CYCLES cycles, then -> IDLE.
  - Changes arriving during SETTLE are ignored until IDLE, then detected normally.
- FAULT:
  - Outputs hold; cfg_timeout=1.
  - Exit only via disable or reset.
- Latency: with dp_busy=0, a change sampled at edge t gives PENDING at t+1. New outputs and cfg_load appear at t+2.
- Enable from disabled takes the normal PENDING/APPLY path.
- Simultaneous events:
  - Disable during APPLY or SETTLE: disable wins and cfg_load drops next cycle.
  - dp_busy falling in the same cycle the counter would hit timeout: APPLY wins.
- Widths: timeout counter is $clog2(TIMEOUT_CYCLES+1) bits, minimum 1; it saturates and never wraps. Settle counter is $clog2(SETTLE_CYCLES+1) bits, minimum 1.
- Reset mid-PENDING or mid-APPLY: returns to reset values; no partial commit is visible.

Optional Feature:
- Macro: SPI_CFG_COMMIT_COUNT_EN.
- Defined: adds output commit_count (16 bits). It increments on every cfg_load pulse, wraps 0xFFFF->0x0000, and is reset to 0. It is not cleared by disable.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package spi_cfg_commit_pkg:
  - State encodings IDLE=3'd0, PENDING=3'd1, APPLY=3'd2, SETTLE=3'd3, FAULT=3'd4.
  - Field width constants 32/15/32.
- One sub-module, cfg_hold_counter:
  - Parameterized saturating up-counter with clear/enable and a terminal flag.
  - Instantiated twice, for timeout and settle.

Test Plan:
1. Reset then cfg_valid=1, spi_en_in=1, trig_lockout_in=0x100, dp_busy=0 -> state PENDING at +1; at +2 trig_lockout=0x100, spi_en=1, cfg_load=1 for one cycle; SETTLE 4 cycles, then IDLE.
2. Change integ_window_in to 0x2000 with dp_busy=1 for 50 cycles -> cfg_pending high for 50 cycles; integ_window updates 1 cycle after dp_busy falls, with a cfg_load pulse.
3. TIMEOUT_CYCLES=16, change with dp_busy held 1 -> FAULT after 16 PENDING cycles, cfg_timeout=1, outputs unchanged. Then spi_en_in=0 -> spi_en=0, cfg_timeout=0, state IDLE.
4. Drop cfg_valid for 1 cycle while in PENDING -> state IDLE, no cfg_load; change re-detected once cfg_valid returns.
5. spi_en_in=0 asserted during the APPLY cycle -> next cycle spi_en=0, state IDLE, no second cfg_load.
6. With SPI_CFG_COMMIT_COUNT_EN, preload by forcing 0xFFFF commits -> next commit wraps commit_count to 0; reset mid-PENDING clears all outputs to 0.
